// File: rtl/cdh_osc_reset_pkg.sv
// rtl/cdh_osc_reset_pkg.sv - shared state encoding and parameter defaults for the oscillator reset sequencer
package cdh_osc_reset_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABILIZE = 3'd1,
        ST_WAIT_INIT = 3'd2,
        ST_STAGGER   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    localparam int STABLE_CYCLES_DEF  = 1024;
    localparam int STAGGER_CYCLES_DEF = 16;
    localparam int TIMEOUT_CYCLES_DEF = 65535;
    localparam int SYNC_STAGES_DEF    = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cdh_sync_ff.sv
// rtl/cdh_sync_ff.sv - multi-flop synchronizer for a single asynchronous level input
module cdh_sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    // Depth is clamped so a mis-set parameter never degrades metastability protection.
    localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdh_osc_reset_seq.sv
// rtl/cdh_osc_reset_seq.sv - lock/init driven MSS and fabric reset release sequencer
module cdh_osc_reset_seq
    import cdh_osc_reset_pkg::*;
#(
    parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
    parameter int STAGGER_CYCLES = STAGGER_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lock_i,
    input  logic       init_done_i,
    output logic       mss_reset_n_o,
    output logic       fab_reset_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int TW = $clog2(max3(STABLE_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] STAGGER_LAST = TW'(STAGGER_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic lock_s;
    logic init_s;

    cdh_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (lock_i),
        .q_o   (lock_s)
    );

    cdh_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_init (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (init_done_i),
        .q_o   (init_s)
    );

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      loss_cnt_q, loss_cnt_d;
    logic            mss_reset_n_q, fab_reset_q, ready_q, fault_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s)
                    state_d = ST_STABILIZE;
                else if (timer_q == TIMEOUT_LAST)
                    state_d = ST_FAULT;
            end
            ST_STABILIZE: begin
                if (!lock_s)
                    state_d = ST_WAIT_LOCK;
                else if (timer_q == STABLE_LAST)
                    state_d = ST_WAIT_INIT;
            end
            ST_WAIT_INIT: begin
                if (!lock_s)
                    state_d = ST_WAIT_LOCK;
                else if (init_s)
                    state_d = ST_STAGGER;
                else if (timer_q == TIMEOUT_LAST)
                    state_d = ST_FAULT;
            end
            ST_STAGGER: begin
                if (!lock_s)
                    state_d = ST_WAIT_LOCK;
                else if (timer_q == STAGGER_LAST)
                    state_d = ST_RUN;
            end
            // init_s is deliberately not consulted once running.
            ST_RUN: begin
                if (!lock_s)
                    state_d = ST_WAIT_LOCK;
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_WAIT_LOCK;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (state_q == ST_RUN && !lock_s && loss_cnt_q != 8'hFF)
            loss_cnt_d = loss_cnt_q + 8'd1;
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_WAIT_LOCK;
            timer_q       <= '0;
            loss_cnt_q    <= 8'd0;
            mss_reset_n_q <= 1'b0;
            fab_reset_q   <= 1'b1;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            loss_cnt_q    <= loss_cnt_d;
            mss_reset_n_q <= (state_d == ST_WAIT_INIT) || (state_d == ST_STAGGER) ||
                             (state_d == ST_RUN);
            fab_reset_q   <= (state_d != ST_RUN);
            ready_q       <= (state_d == ST_RUN);
            fault_q       <= (state_d == ST_FAULT);
        end
    end

    assign mss_reset_n_o   = mss_reset_n_q;
    assign fab_reset_o     = fab_reset_q;
    assign ready_o         = ready_q;
    assign fault_o         = fault_q;
    assign lock_loss_cnt_o = loss_cnt_q;

endmodule

// File: tb/tb_cdh_osc_reset_seq.sv
// tb/tb_cdh_osc_reset_seq.sv - directed self-checking bench for cdh_osc_reset_seq
module tb_cdh_osc_reset_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       init_done;
    logic       mss_reset_n;
    logic       fab_reset;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cdh_osc_reset_seq #(
        .STABLE_CYCLES  (8),
        .STAGGER_CYCLES (4),
        .TIMEOUT_CYCLES (100),
        .SYNC_STAGES    (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lock_i          (lock),
        .init_done_i     (init_done),
        .mss_reset_n_o   (mss_reset_n),
        .fab_reset_o     (fab_reset),
        .ready_o         (ready),
        .fault_o         (fault),
        .lock_loss_cnt_o (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves lock/init at the given levels so they count as applied before edge 1.
    task automatic do_reset(input logic l, input logic i);
        rst = 1'b1;
        lock = l;
        init_done = i;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1'b0, 1'b0);
        rst = 1'b1;
        step(1);
        n_checks++;
        if ({mss_reset_n, fab_reset, ready, fault} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0100", {mss_reset_n, fab_reset, ready, fault});
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", lock_loss_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_power_up;
        do_reset(1'b1, 1'b0);
        step(10);
        n_checks++;
        if (mss_reset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL pu_mss_edge10: got %b expected 0", mss_reset_n);
        end
        step(1);
        n_checks++;
        if ({mss_reset_n, fab_reset, ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL pu_mss_edge11: got %b expected 110", {mss_reset_n, fab_reset, ready});
        end
        step(9);
        init_done = 1'b1;
        step(6);
        n_checks++;
        if ({mss_reset_n, fab_reset, ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL pu_stagger_edge26: got %b expected 110", {mss_reset_n, fab_reset, ready});
        end
        step(1);
        n_checks++;
        if ({mss_reset_n, fab_reset, ready, fault} !== 4'b1010) begin
            n_fail++;
            $display("FAIL pu_run_edge27: got %b expected 1010", {mss_reset_n, fab_reset, ready, fault});
        end
    endtask

    task automatic test_glitch;
        do_reset(1'b1, 1'b0);
        step(5);
        lock = 1'b0;
        step(1);
        lock = 1'b1;
        step(10);
        n_checks++;
        if (mss_reset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_edge16: got %b expected 0", mss_reset_n);
        end
        step(1);
        n_checks++;
        if (mss_reset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_edge17: got %b expected 1", mss_reset_n);
        end
    endtask

    task automatic test_timeout;
        do_reset(1'b0, 1'b0);
        step(99);
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_edge99: got %b expected 0", fault);
        end
        step(1);
        n_checks++;
        if ({mss_reset_n, fab_reset, ready, fault} !== 4'b0101) begin
            n_fail++;
            $display("FAIL timeout_edge100: got %b expected 0101", {mss_reset_n, fab_reset, ready, fault});
        end
        lock = 1'b1;
        init_done = 1'b1;
        step(20);
        n_checks++;
        if ({mss_reset_n, fault} !== 2'b01) begin
            n_fail++;
            $display("FAIL fault_terminal: got %b expected 01", {mss_reset_n, fault});
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++;
        if ({mss_reset_n, fab_reset, ready, fault} !== 4'b0100) begin
            n_fail++;
            $display("FAIL fault_cleared: got %b expected 0100", {mss_reset_n, fab_reset, ready, fault});
        end
        step(11);
        n_checks++;
        if (mss_reset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_resequence: got %b expected 1", mss_reset_n);
        end
    endtask

    // Lock and init both high from edge 1 reaches RUN at edge 16.
    task automatic bring_up;
        do_reset(1'b1, 1'b1);
        step(16);
    endtask

    task automatic test_lock_loss;
        bring_up();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ll_ready: got %b expected 1", ready);
        end
        init_done = 1'b0;
        step(10);
        n_checks++;
        if ({ready, fab_reset} !== 2'b10) begin
            n_fail++;
            $display("FAIL ll_init_ignored: got %b expected 10", {ready, fab_reset});
        end
        init_done = 1'b1;
        lock = 1'b0;
        step(2);
        n_checks++;
        if (fab_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL ll_edge2: got %b expected 0", fab_reset);
        end
        step(1);
        n_checks++;
        if ({mss_reset_n, fab_reset, ready} !== 3'b010 || lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ll_edge3: got %b cnt %0d expected 010 cnt 1", {mss_reset_n, fab_reset, ready}, lock_loss_cnt);
        end
        lock = 1'b1;
        step(10);
        n_checks++;
        if (mss_reset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_edge10: got %b expected 0", mss_reset_n);
        end
        step(5);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_edge15: got %b expected 0", ready);
        end
        step(1);
        n_checks++;
        if (ready !== 1'b1 || lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_edge16: got ready %b cnt %0d expected 1 cnt 1", ready, lock_loss_cnt);
        end
    endtask

    task automatic test_saturate;
        int not_ready;
        not_ready = 0;
        bring_up();
        for (int i = 1; i <= 300; i++) begin
            lock = 1'b0;
            step(3);
            lock = 1'b1;
            step(16);
            if (ready !== 1'b1) not_ready++;
            if (i == 254) begin
                n_checks++;
                if (lock_loss_cnt !== 8'd254) begin
                    n_fail++;
                    $display("FAIL sat_254: got %0d expected 254", lock_loss_cnt);
                end
            end
        end
        n_checks++;
        if (lock_loss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_300: got %0d expected 255", lock_loss_cnt);
        end
        n_checks++;
        if (not_ready !== 0) begin
            n_fail++;
            $display("FAIL sat_relock_ready: got %0d misses expected 0", not_ready);
        end
    endtask

    task automatic test_rst_mid;
        bring_up();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++;
        if ({mss_reset_n, fab_reset, ready, fault} !== 4'b0100 || lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_in_run: got %b cnt %0d expected 0100 cnt 0", {mss_reset_n, fab_reset, ready, fault}, lock_loss_cnt);
        end
        do_reset(1'b1, 1'b1);
        step(13);
        n_checks++;
        if ({mss_reset_n, ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL stagger_reached: got %b expected 10", {mss_reset_n, ready});
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_checks++;
        if ({mss_reset_n, fab_reset, ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL rst_in_stagger: got %b expected 010", {mss_reset_n, fab_reset, ready});
        end
        step(10);
        n_checks++;
        if (mss_reset_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stagger_edge10: got %b expected 0", mss_reset_n);
        end
        step(1);
        n_checks++;
        if (mss_reset_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stagger_edge11: got %b expected 1", mss_reset_n);
        end
    endtask

    initial begin
        rst = 1'b1;
        lock = 1'b0;
        init_done = 1'b0;
        test_reset();
        test_power_up();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_saturate();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdh_osc_reset_seq.md
CDH_OSC_RESET_SEQ -- requirements
Module: cdh_osc_reset_seq

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-LOCK-high cycles required before reset release.
REQ-002 SHALL have parameter STAGGER_CYCLES, default 16: cycles between synchronized INIT_DONE high and fabric reset release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum wait in WAIT_LOCK or WAIT_INIT before FAULT.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: flop depth of each input synchronizer, minimum 2.
REQ-005 CLK  in  1  fabric clock, 50 MHz RC oscillator via CLKINT (RCOSC_25_50MHZ_O2F); only clock.
REQ-006 RST  in  1  reset, synchronous to CLK, active-high.
REQ-007 LOCK  in  1  CCC lock, asynchronous to CLK.
REQ-008 INIT_DONE  in  1  MSS/system init complete, asynchronous to CLK.
REQ-009 MSS_RESET_N  out  1  MSS reset, active-low, registered.
REQ-010 FAB_RESET  out  1  fabric reset, active-high, registered.
REQ-011 READY  out  1  high only in RUN, registered.
REQ-012 FAULT  out  1  high only in FAULT, registered.
REQ-013 LOCK_LOSS_CNT  out  8  count of lock losses from RUN, saturating.

Function
REQ-014 LOCK and INIT_DONE SHALL each pass through SYNC_STAGES flops; FSM uses only synchronized lock_s, init_s.
REQ-015 FSM states: WAIT_LOCK, STABILIZE, WAIT_INIT, STAGGER, RUN, FAULT; one shared timer, cleared on every state change.
REQ-016 WAIT_LOCK: lock_s=1 -> STABILIZE; timer reaching TIMEOUT_CYCLES-1 with lock_s=0 -> FAULT; lock_s wins if both same cycle.
REQ-017 STABILIZE: lock_s=0 -> WAIT_LOCK; timer reaching STABLE_CYCLES-1 with lock_s=1 -> WAIT_INIT.
REQ-018 WAIT_INIT: MSS_RESET_N=1; init_s=1 -> STAGGER; lock_s=0 -> WAIT_LOCK (priority over init_s); timeout as REQ-016 -> FAULT.
REQ-019 STAGGER: lock_s=0 -> WAIT_LOCK; timer reaching STAGGER_CYCLES-1 -> RUN.
REQ-020 RUN: FAB_RESET=0, READY=1; lock_s=0 -> WAIT_LOCK and LOCK_LOSS_CNT+1, holding at 255.
REQ-021 init_s falling in RUN SHALL be ignored.
REQ-022 FAULT SHALL be terminal until RST; MSS_RESET_N=0, FAB_RESET=1.
REQ-023 Outputs registered from next state: MSS_RESET_N=1 in WAIT_INIT, STAGGER, RUN only; FAB_RESET=0 in RUN only.
REQ-024 LOCK falling in RUN SHALL assert FAB_RESET and deassert MSS_RESET_N within SYNC_STAGES+1 CLK edges.
REQ-025 Timer width SHALL be ceil(log2(max(STABLE_CYCLES,STAGGER_CYCLES,TIMEOUT_CYCLES)+1)); no wrap (cleared per REQ-015).

Reset
REQ-026 RST=1 at a CLK edge SHALL force WAIT_LOCK, timer=0, synchronizers=0, LOCK_LOSS_CNT=0, MSS_RESET_N=0, FAB_RESET=1, READY=0, FAULT=0.
REQ-027 RST asserted mid-sequence, including RUN or FAULT, SHALL take effect at the next edge with no intermediate state.

Structure
REQ-028 Package cdh_osc_reset_pkg SHALL hold the state enum and parameter defaults.
REQ-029 Synchronizer SHALL be sub-module cdh_sync_ff (parameter SYNC_STAGES), instantiated twice.

Verification (STABLE_CYCLES=8, STAGGER_CYCLES=4, TIMEOUT_CYCLES=100, SYNC_STAGES=2)
REQ-030 LOCK=1 at cycle 0, INIT_DONE=1 at cycle 20 -> MSS_RESET_N rises ~cycle 11; FAB_RESET falls, READY rises ~cycle 27.
REQ-031 LOCK glitches low 1 cycle during STABILIZE -> return to WAIT_LOCK; release delayed by a full 8 stable cycles.
REQ-032 LOCK never high -> FAULT=1 at cycle ~101; outputs held in reset; RST pulse -> WAIT_LOCK, FAULT=0.
REQ-033 LOCK drops in RUN -> FAB_RESET=1, MSS_RESET_N=0 within 3 edges, LOCK_LOSS_CNT=1; relock -> full resequence.
REQ-034 300 lock losses from RUN -> LOCK_LOSS_CNT holds 255.
REQ-035 RST in STAGGER -> next edge: FAB_RESET=1, MSS_RESET_N=0, READY=0, WAIT_LOCK.
